// File: rtl/dense_layer_if.sv
// dense_layer_if: control, configuration and shared-RAM bus of the dense layer stage.
//   dense_en      level enable (driven by the sequencer)
//   in_count      inputs per neuron N
//   out_count     output neurons M
//   memstartp     activation vector base address
//   memstartw     weight matrix base address (row-major, one row per neuron)
//   memstartzap   output vector base address
//   read_addressp activation read address;  qp  activation read data
//   read_addressw weight read address;      qw  weight read data
//   re            read enable for both RAMs
//   write_addressp output write address;    dp  output data;  we  write strobe
//   STOP          done flag
// master: the dense layer; slave: sequencer plus memories.
interface dense_layer_if #(
   parameter int unsigned SIZE_1           = 11,
   parameter int unsigned SIZE_W           = 9,
   parameter int unsigned SIZE_address_pix = 13,
   parameter int unsigned SIZE_address_wei = 16
);
   logic                        dense_en;
   logic [9:0]                  in_count;
   logic [9:0]                  out_count;
   logic [SIZE_address_pix-1:0] memstartp;
   logic [SIZE_address_wei-1:0] memstartw;
   logic [SIZE_address_pix-1:0] memstartzap;
   logic [SIZE_address_pix-1:0] read_addressp;
   logic [SIZE_address_wei-1:0] read_addressw;
   logic                        re;
   logic signed [SIZE_1-1:0]    qp;
   logic signed [SIZE_W-1:0]    qw;
   logic [SIZE_address_pix-1:0] write_addressp;
   logic signed [SIZE_1-1:0]    dp;
   logic                        we;
   logic                        STOP;

   modport master (
      input  dense_en, in_count, out_count, memstartp, memstartw, memstartzap, qp, qw,
      output read_addressp, read_addressw, re, write_addressp, dp, we, STOP
   );

   modport slave (
      output dense_en, in_count, out_count, memstartp, memstartw, memstartzap, qp, qw,
      input  read_addressp, read_addressw, re, write_addressp, dp, we, STOP
   );
endinterface

// File: rtl/dense_layer.sv
// dense_layer: fully-connected stage after max-pooling.
// For each output neuron o it streams x[k] and w[o*N+k] from the shared RAMs, accumulates
// the signed products, then writes sat((acc >>> SHIFT)) to memstartzap+o.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (priority over dense_en)
//   bus   dense_layer_if.master: enable/config in, RAM read/write master out, STOP out
// Build option: define DENSE_RELU_EN to clamp negative results to 0 before the write.
module dense_layer #(
   parameter int unsigned SIZE_1           = 11,
   parameter int unsigned SIZE_W           = 9,
   parameter int unsigned SIZE_ACC         = 32,
   parameter int unsigned SHIFT            = 8,
   parameter int unsigned SIZE_address_pix = 13,
   parameter int unsigned SIZE_address_wei = 16
) (
   input logic         clk,
   input logic         rst,
   dense_layer_if.master bus
);
   localparam int unsigned SizeProd = SIZE_1 + SIZE_W;
   localparam logic signed [SIZE_ACC-1:0] SatMax =
      SIZE_ACC'((64'sd1 <<< (SIZE_1 - 1)) - 64'sd1);
   localparam logic signed [SIZE_ACC-1:0] SatMin =
      SIZE_ACC'(-(64'sd1 <<< (SIZE_1 - 1)));
   localparam logic [SIZE_address_pix-1:0] OneP = SIZE_address_pix'(1);
   localparam logic [SIZE_address_wei-1:0] OneW = SIZE_address_wei'(1);

   typedef enum logic [2:0] {StIdle, StIssue, StDrain, StWrite, StDone} state_e;

   state_e                      state_q, state_d;
   logic [9:0]                  n_q, n_d, m_q, m_d;
   logic [9:0]                  k_q, k_d;     // addresses issued for the current neuron
   logic [9:0]                  o_q, o_d;     // neurons written so far
   logic                        drain_q, drain_d;
   logic [SIZE_address_pix-1:0] basep_q, basep_d;
   logic [SIZE_address_pix-1:0] zap_q, zap_d; // next output address
   logic [SIZE_address_pix-1:0] addrp_q, addrp_d;
   logic [SIZE_address_wei-1:0] addrw_q, addrw_d; // running weight pointer, never rewound
   logic [SIZE_address_pix-1:0] waddr_q, waddr_d;
   logic                        re_q, re_d, we_q, we_d, stop_q, stop_d;
   logic                        rdv_q, rdv_d; // RAM data for an issued address arrives next edge
   logic signed [SIZE_1-1:0]    dp_q, dp_d;
   logic signed [SIZE_ACC-1:0]  acc_q, acc_d;

   logic signed [SizeProd-1:0]  qp_ext, qw_ext, prod;
   logic signed [SIZE_ACC-1:0]  prod_ext, shifted;
   logic signed [SIZE_1-1:0]    sat_val, wr_val;

   always_comb begin
      qp_ext   = SizeProd'(bus.qp);
      qw_ext   = SizeProd'(bus.qw);
      prod     = qp_ext * qw_ext;
      prod_ext = SIZE_ACC'(prod);
      shifted  = acc_q >>> SHIFT;
      if (shifted > SatMax) begin
         sat_val = {1'b0, {(SIZE_1 - 1){1'b1}}};
      end else if (shifted < SatMin) begin
         sat_val = {1'b1, {(SIZE_1 - 1){1'b0}}};
      end else begin
         sat_val = shifted[SIZE_1-1:0];
      end
`ifdef DENSE_RELU_EN
      wr_val = sat_val[SIZE_1-1] ? '0 : sat_val;
`else
      wr_val = sat_val;
`endif
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      m_d     = m_q;
      k_d     = k_q;
      o_d     = o_q;
      drain_d = drain_q;
      basep_d = basep_q;
      zap_d   = zap_q;
      addrp_d = addrp_q;
      addrw_d = addrw_q;
      waddr_d = waddr_q;
      dp_d    = dp_q;
      re_d    = 1'b0;
      we_d    = 1'b0;
      stop_d  = 1'b0;
      rdv_d   = re_q;
      acc_d   = rdv_q ? acc_q + prod_ext : acc_q;

      if (!bus.dense_en) begin
         // Abort: clear everything; results already written stay in memory.
         state_d = StIdle;
         k_d     = '0;
         o_d     = '0;
         drain_d = 1'b0;
         rdv_d   = 1'b0;
         acc_d   = '0;
         addrp_d = '0;
         addrw_d = '0;
         waddr_d = '0;
         dp_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               n_d     = bus.in_count;
               m_d     = bus.out_count;
               basep_d = bus.memstartp;
               zap_d   = bus.memstartzap;
               o_d     = '0;
               if (bus.in_count == 10'd0 || bus.out_count == 10'd0) begin
                  state_d = StDone;
                  stop_d  = 1'b1;
               end else begin
                  state_d = StIssue;
                  re_d    = 1'b1;
                  addrp_d = bus.memstartp;
                  addrw_d = bus.memstartw;
                  k_d     = 10'd1;
               end
            end
            StIssue: begin
               if (k_q == n_q) begin
                  state_d = StDrain;
                  drain_d = 1'b0;
               end else begin
                  re_d    = 1'b1;
                  addrp_d = addrp_q + OneP;
                  addrw_d = addrw_q + OneW;
                  k_d     = k_q + 10'd1;
               end
            end
            StDrain: begin
               // Two cycles let the last product land in acc_q.
               if (drain_q) begin
                  state_d = StWrite;
                  we_d    = 1'b1;
                  dp_d    = wr_val;
                  waddr_d = zap_q;
               end else begin
                  drain_d = 1'b1;
               end
            end
            StWrite: begin
               acc_d = '0;
               o_d   = o_q + 10'd1;
               zap_d = zap_q + OneP;
               k_d   = '0;
               if ((o_q + 10'd1) == m_q) begin
                  state_d = StDone;
                  stop_d  = 1'b1;
               end else begin
                  state_d = StIssue;
                  re_d    = 1'b1;
                  addrp_d = basep_q;
                  addrw_d = addrw_q + OneW; // next row follows the previous one
                  k_d     = 10'd1;
               end
            end
            StDone: begin
               stop_d = 1'b1;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         n_q     <= '0;
         m_q     <= '0;
         k_q     <= '0;
         o_q     <= '0;
         drain_q <= 1'b0;
         basep_q <= '0;
         zap_q   <= '0;
         addrp_q <= '0;
         addrw_q <= '0;
         waddr_q <= '0;
         dp_q    <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         stop_q  <= 1'b0;
         rdv_q   <= 1'b0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         m_q     <= m_d;
         k_q     <= k_d;
         o_q     <= o_d;
         drain_q <= drain_d;
         basep_q <= basep_d;
         zap_q   <= zap_d;
         addrp_q <= addrp_d;
         addrw_q <= addrw_d;
         waddr_q <= waddr_d;
         dp_q    <= dp_d;
         re_q    <= re_d;
         we_q    <= we_d;
         stop_q  <= stop_d;
         rdv_q   <= rdv_d;
         acc_q   <= acc_d;
      end
   end

   assign bus.read_addressp  = addrp_q;
   assign bus.read_addressw  = addrw_q;
   assign bus.re             = re_q;
   assign bus.write_addressp = waddr_q;
   assign bus.dp             = dp_q;
   assign bus.we             = we_q;
   assign bus.STOP           = stop_q;
endmodule

// File: tb/tb_dense_layer.sv
`timescale 1ns/1ps
module tb_dense_layer;
   localparam int unsigned S1  = 11;
   localparam int unsigned SW  = 9;
   localparam int unsigned SP  = 13;
   localparam int unsigned SWA = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dense_layer_if #(.SIZE_1(S1), .SIZE_W(SW), .SIZE_address_pix(SP),
                    .SIZE_address_wei(SWA)) b0 ();
   dense_layer_if #(.SIZE_1(S1), .SIZE_W(SW), .SIZE_address_pix(SP),
                    .SIZE_address_wei(SWA)) b8 ();

   dense_layer #(.SIZE_1(S1), .SIZE_W(SW), .SIZE_ACC(32), .SHIFT(0),
                 .SIZE_address_pix(SP), .SIZE_address_wei(SWA))
      u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   dense_layer #(.SIZE_1(S1), .SIZE_W(SW), .SIZE_ACC(32), .SHIFT(8),
                 .SIZE_address_pix(SP), .SIZE_address_wei(SWA))
      u_dut8 (.clk(clk), .rst(rst), .bus(b8));

   logic signed [S1-1:0] mem_p [0:(1<<SP)-1];
   logic signed [SW-1:0] mem_w [0:(1<<SWA)-1];

   // One-cycle-latency RAMs shared by both instances.
   always @(posedge clk) begin
      if (b0.re) begin
         b0.qp <= mem_p[b0.read_addressp];
         b0.qw <= mem_w[b0.read_addressw];
      end
      if (b8.re) begin
         b8.qp <= mem_p[b8.read_addressp];
         b8.qw <= mem_w[b8.read_addressw];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int addr;
      int data;
      int edge_n;
   } exp_t;
   exp_t q0[$];
   exp_t q8[$];

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   function automatic int relu(input int v);
`ifdef DENSE_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic push0(input int addr, input int data, input int edge_n);
      exp_t e;
      e.addr = addr; e.data = data; e.edge_n = edge_n;
      q0.push_back(e);
   endtask

   task automatic push8(input int addr, input int data, input int edge_n);
      exp_t e;
      e.addr = addr; e.data = data; e.edge_n = edge_n;
      q8.push_back(e);
   endtask

   // Monitor: every write strobe is matched against the next expected write.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (b0.we) begin
            if (q0.size() == 0) begin
               chk("dut0_spurious_we", int'(b0.we), 0);
            end else begin
               e = q0.pop_front();
               chk("dut0_waddr", int'(b0.write_addressp), e.addr);
               chk("dut0_dp", int'(b0.dp), e.data);
               chk("dut0_we_edge", cyc, e.edge_n);
            end
         end
         if (b8.we) begin
            if (q8.size() == 0) begin
               chk("dut8_spurious_we", int'(b8.we), 0);
            end else begin
               e = q8.pop_front();
               chk("dut8_waddr", int'(b8.write_addressp), e.addr);
               chk("dut8_dp", int'(b8.dp), e.data);
               chk("dut8_we_edge", cyc, e.edge_n);
            end
         end
      end
   end

   // Called right after a negedge; the next posedge is edge 0.
   task automatic start0(input int n, input int m, input int p, input int w, input int z,
                         output int base);
      b0.in_count    = n[9:0];
      b0.out_count   = m[9:0];
      b0.memstartp   = p[SP-1:0];
      b0.memstartw   = w[SWA-1:0];
      b0.memstartzap = z[SP-1:0];
      b0.dense_en    = 1'b1;
      base = cyc + 1;
   endtask

   task automatic wait_stop0(input string name, input int exp_edge);
      int k = 0;
      while (!b0.STOP && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_stop"}, int'(b0.STOP), 1);
      chk({name, "_edge"}, cyc, exp_edge);
   endtask

   task automatic stop0(input string name);
      b0.dense_en = 1'b0;
      @(negedge clk);
      chk({name, "_stop_clear"}, int'(b0.STOP), 0);
   endtask

   task automatic outs_zero(input string name);
      chk({name, "_re"}, int'(b0.re), 0);
      chk({name, "_we"}, int'(b0.we), 0);
      chk({name, "_stop"}, int'(b0.STOP), 0);
      chk({name, "_raddrp"}, int'(b0.read_addressp), 0);
      chk({name, "_raddrw"}, int'(b0.read_addressw), 0);
      chk({name, "_waddr"}, int'(b0.write_addressp), 0);
      chk({name, "_dp"}, int'(b0.dp), 0);
   endtask

   task automatic load_t1();
      for (int i = 0; i < 4; i++) mem_p[100 + i] = 11'(i + 1);
      for (int i = 0; i < 4; i++) mem_w[200 + i] = 9'sd1;
      mem_w[204] = -9'sd1;
      for (int i = 5; i < 8; i++) mem_w[200 + i] = 9'sd0;
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int base;
      int nb;
      int saw_re;
      int k;
      rst = 1'b1;
      b0.dense_en = 1'b0; b0.in_count = '0; b0.out_count = '0;
      b0.memstartp = '0; b0.memstartw = '0; b0.memstartzap = '0;
      b8.dense_en = 1'b0; b8.in_count = '0; b8.out_count = '0;
      b8.memstartp = '0; b8.memstartw = '0; b8.memstartzap = '0;
      repeat (3) @(negedge clk);
      outs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // N=4, M=2 basic run.
      load_t1();
      start0(4, 2, 100, 200, 300, base);
      push0(300, 10, base + 6);
      push0(301, relu(-1), base + 13);
      @(negedge clk);
      chk("t1_re_edge0", int'(b0.re), 1);
      chk("t1_raddrp_edge0", int'(b0.read_addressp), 100);
      chk("t1_raddrw_edge0", int'(b0.read_addressw), 200);
      wait_stop0("t1", base + 14);
      stop0("t1");

      // Saturation high then low.
      for (int i = 0; i < 4; i++) begin
         mem_p[400 + i] = 11'sd1023;
         mem_w[500 + i] = 9'sd255;
      end
      start0(4, 1, 400, 500, 600, base);
      push0(600, 1023, base + 6);
      wait_stop0("sat_hi", base + 7);
      stop0("sat_hi");
      for (int i = 0; i < 4; i++) mem_p[400 + i] = -11'sd1024;
      start0(4, 1, 400, 500, 600, base);
      push0(600, relu(-1024), base + 6);
      wait_stop0("sat_lo", base + 7);
      stop0("sat_lo");

      // Abort: dense_en low sampled at edge 3, then a clean restart.
      start0(4, 2, 100, 200, 300, base);
      repeat (3) @(negedge clk);
      b0.dense_en = 1'b0;
      @(negedge clk);
      chk("abort_re", int'(b0.re), 0);
      chk("abort_stop", int'(b0.STOP), 0);
      repeat (20) @(negedge clk);
      start0(4, 2, 100, 200, 300, base);
      push0(300, 10, base + 6);
      push0(301, relu(-1), base + 13);
      wait_stop0("restart", base + 14);
      stop0("restart");

      // Reset pulse at edge 8 with dense_en held high.
      start0(4, 2, 100, 200, 300, base);
      push0(300, 10, base + 6);
      while (cyc < base + 7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      outs_zero("rst_pulse");
      rst = 1'b0;
      nb = base + 9;
      push0(300, 10, nb + 6);
      push0(301, relu(-1), nb + 13);
      wait_stop0("rst_rerun", nb + 14);
      stop0("rst_rerun");

      // N=0: straight to done, no memory traffic.
      start0(0, 3, 100, 200, 300, base);
      @(negedge clk);
      chk("n0_stop_edge0", int'(b0.STOP), 1);
      saw_re = int'(b0.re);
      repeat (10) begin
         @(negedge clk);
         if (b0.re) saw_re = 1;
      end
      chk("n0_no_re", saw_re, 0);
      stop0("n0");

      // SHIFT=8 instance: 512*3 >>> 8 = 6, -512*3 >>> 8 = -6.
      mem_p[700] = 11'sd512;
      mem_w[800] = 9'sd3;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) mem_p[700] = -11'sd512;
         b8.in_count = 10'd1; b8.out_count = 10'd1;
         b8.memstartp = 13'd700; b8.memstartw = 16'd800; b8.memstartzap = 13'd900;
         b8.dense_en = 1'b1;
         base = cyc + 1;
         push8(900, (pass == 0) ? 6 : relu(-6), base + 3);
         k = 0;
         while (!b8.STOP && k < 300) begin
            @(negedge clk);
            k++;
         end
         chk("shift8_stop", int'(b8.STOP), 1);
         chk("shift8_stop_edge", cyc, base + 4);
         b8.dense_en = 1'b0;
         @(negedge clk);
         chk("shift8_stop_clear", int'(b8.STOP), 0);
      end

      repeat (5) @(negedge clk);
      chk("dut0_pending_writes", q0.size(), 0);
      chk("dut8_pending_writes", q8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dense_layer.md
# dense_layer

Fully-connected layer stage that sits directly downstream of max-pooling in the digit-detector datapath. Once `dense_en` is raised, it reads the pooled feature vector and a row-major weight matrix from memory. For each output neuron it multiplies and accumulates the inputs against that neuron's weight row, then rescales and saturates the sum. Each result is written back to memory, and `STOP` is raised when all outputs are written. Control style matches the neighbouring stages: level enable, `STOP` completion flag, address-generating master on shared RAMs.

## Interface
- `SIZE_1`, 11: signed width of activations (`qp`, `dp`)
- `SIZE_W`, 9: signed width of weights (`qw`)
- `SIZE_ACC`, 32: accumulator width; must be ≥ `SIZE_1`+`SIZE_W`+10
- `SHIFT`, 8: arithmetic right shift applied to the accumulator before saturation
- `SIZE_address_pix`, 13: activation address width
- `SIZE_address_wei`, 16: weight address width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `dense_en`  in  1  level enable; low aborts and clears the block
- `in_count`  in  10  number of inputs per neuron (N)
- `out_count`  in  10  number of output neurons (M)
- `memstartp`  in  `SIZE_address_pix`  base address of the input vector
- `memstartw`  in  `SIZE_address_wei`  base address of the weight matrix
- `memstartzap`  in  `SIZE_address_pix`  base address of the output vector
- `read_addressp`  out  `SIZE_address_pix`  activation read address
- `read_addressw`  out  `SIZE_address_wei`  weight read address
- `re`  out  1  read enable (both RAMs)
- `qp`  in  `SIZE_1` signed  activation read data
- `qw`  in  `SIZE_W` signed  weight read data
- `write_addressp`  out  `SIZE_address_pix`  output write address
- `dp`  out  `SIZE_1` signed  output write data
- `we`  out  1  write enable, one-cycle pulse per output
- `STOP`  out  1  done flag

## Operation
- Computes `y[o] = sat((Σk x[k]·w[o·N+k]) >>> SHIFT)` for o = 0..M−1.
  - `x[k]` is read at `memstartp+k`.
  - `w[o·N+k]` is read at `memstartw+o·N+k`.
  - `y[o]` is written to `memstartzap+o`.
- The weight address is kept as a running pointer. No multiplier is used for addressing.
- Arithmetic:
  - Each product is the full `SIZE_1+SIZE_W`-bit signed product, sign-extended into `SIZE_ACC`.
  - The accumulator wraps silently; sizing it is the integrator's responsibility.
  - Saturation clamps to [−2^(`SIZE_1`−1), 2^(`SIZE_1`−1)−1].
- States:
  - `IDLE`: waits for `dense_en`.
  - `ISSUE`: N cycles; one address pair per cycle; `re`=1.
  - `DRAIN`: 2 cycles; `re`=0; completes the last accumulations.
  - `WRITE`: 1 cycle; `we`=1; clears the accumulator; advances o.
  - After `WRITE`: go to `ISSUE` if o<M, otherwise to `DONE`.
  - `DONE`: `STOP`=1; holds while `dense_en`=1.
- `dense_en` low in any state: next edge goes to `IDLE` with `re`=`we`=`STOP`=0, counters and accumulator cleared. Partial results already written are not undone.
- N=0 or M=0: `IDLE`→`DONE` directly; no reads, no writes.

## Timing
- Memory read latency: an address registered at edge E is captured by the RAM at E+1. The block consumes `qp`/`qw` at E+2.
- Edge 0 is the first edge where `IDLE` samples `dense_en`=1 (`rst`=0):
  - The first address pair is registered at edge 0.
  - Issue for neuron o occupies edges o·(N+3) … o·(N+3)+N−1.
  - The `WRITE` for neuron o is at edge o·(N+3)+N+2. `we`, `dp` and `write_addressp` are valid for the following cycle.
- `STOP` rises at edge M·(N+3) and stays high until `dense_en` falls. Clearing takes one edge.
- Reset: every output is 0 at the edge where `rst`=1 (addresses, `dp`, `re`, `we`, `STOP`), and the state is `IDLE`. `rst` takes priority over `dense_en`.
- `in_count`/`out_count`/base addresses are sampled only in `IDLE`. Changes mid-run are ignored.

## Configuration
- `DENSE_RELU_EN` defined: after saturation, negative results are written as 0 (ReLU fused into the write path).
- `DENSE_RELU_EN` undefined: signed saturated values are written unchanged.

## Test plan
- N=4, M=2, SHIFT=0, x=[1,2,3,4], w=[1,1,1,1, −1,0,0,0] → writes 10 @`memstartzap`, −1 @`memstartzap+1` (0 with `DENSE_RELU_EN`). `we` pulses at edges 6 and 13; `STOP` rises at edge 14.
- SIZE_1=11, N=4, M=1, SHIFT=0, x=all 1023, w=all 255 → `dp`=1023 (saturated); with x=all −1024 and w=255 → `dp`=−1024 (0 with ReLU).
- SHIFT=8, N=1, x=[512], w=[3] → 1536>>>8 = 6; x=[−512] → −6 (floor).
- `dense_en` dropped at edge 3 of a N=4, M=2 run → no `we` ever; `re`=0 and `STOP`=0 after the next edge; a restart produces correct full results.
- `rst` pulsed at edge 8 with `dense_en` held high → all outputs 0 next cycle; the run restarts from edge 0 and gives correct results.
- N=0, M=3 → `STOP`=1 one edge after enable, `re`/`we` never asserted.
